// File: rtl/bayer_window_5x5.sv
// -----------------------------------------------------------------------------
// bayer_window_5x5
//
// Builds the 5x5 Bayer neighbourhood around a centre pixel from a raster
// stream. The window is handed to the per-colour demosaic kernels. Four line
// buffers hold the previous four lines. A 5x5 register array shifts one column
// left for every accepted pixel.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   in_valid      pixel qualifier (no backpressure, gaps allowed)
//   in_sof        start of frame, only meaningful with in_valid
//   in_data       raster pixel, DATA_W bits
//   out_valid     one-cycle window qualifier, 1 clk after the D55 accept
//   out_win       25*DATA_W window, Drc at [((r-1)*5+(c-1))*DATA_W +: DATA_W]
//   out_color     colour of centre D33: 0=R, 1=Gr, 2=Gb, 3=B
//   out_frame_err one-cycle pulse when in_sof arrives with counters not at
//                 (0,0). Present only when BAYER_WIN_FRAME_CHECK_EN is
//                 defined; otherwise tied to 0.
//
// Optional feature macro: BAYER_WIN_FRAME_CHECK_EN
// -----------------------------------------------------------------------------
module bayer_window_5x5 #(
   parameter int DATA_W        = 10,
   parameter int IMG_W         = 640,
   parameter int IMG_H         = 480,
   parameter int BAYER_PATTERN = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_sof,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  out_valid,
   output logic [25*DATA_W-1:0]  out_win,
   output logic [1:0]            out_color,
   output logic                  out_frame_err
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_FOUR = CW'(4);
   localparam logic [RW-1:0] ROW_FOUR = RW'(4);
   // Colour phase of pixel (0,0) relative to RGGB: bit1 flips row parity,
   // bit0 flips column parity.
   localparam logic [1:0]    PHASE    = 2'(BAYER_PATTERN);

   logic                       acc;
   logic [CW-1:0]              col_q, col_d, cur_col;
   logic [RW-1:0]              row_q, row_d, cur_row;
   logic [DATA_W-1:0]          lb_q [4][IMG_W];
   logic [DATA_W-1:0]          lb_rd [4];
   logic [24:0][DATA_W-1:0]    win_q, win_d;
   logic                       valid_q, valid_d;
   logic [1:0]                 color_q, color_d;

   // Reset wins over a coincident pixel, so the pixel after reset is (0,0).
   assign acc = in_valid & ~rst;

   // An accepted in_sof pixel is (0,0) whatever the counters say.
   assign cur_col = (in_sof) ? '0 : col_q;
   assign cur_row = (in_sof) ? '0 : row_q;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (acc) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
         end else begin
            col_d = cur_col + CW'(1);
            row_d = cur_row;
         end
      end
   end

   // Asynchronous read at the accepted column; values are pre-write.
   always_comb begin
      for (int i = 0; i < 4; i++) lb_rd[i] = lb_q[i][cur_col];
   end

   // Line buffers cascade: the column of the four previous lines moves down
   // one buffer per accept. Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (acc) begin
         lb_q[0][cur_col] <= in_data;
         lb_q[1][cur_col] <= lb_rd[0];
         lb_q[2][cur_col] <= lb_rd[1];
         lb_q[3][cur_col] <= lb_rd[2];
      end
   end

   // Window element index is (row*5 + col), 0-based, which is exactly the
   // out_win packing. The oldest line (LB3) lands in row 1.
   always_comb begin
      win_d = win_q;
      if (acc) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) win_d[r*5+c] = win_q[r*5+c+1];
         end
         win_d[4]  = lb_rd[3];
         win_d[9]  = lb_rd[2];
         win_d[14] = lb_rd[1];
         win_d[19] = lb_rd[0];
         win_d[24] = in_data;
      end
   end

   // Centre is (row-2, col-2), which has the same parity as (row, col).
   always_comb begin
      valid_d = acc && (cur_row >= ROW_FOUR) && (cur_col >= COL_FOUR);
      color_d = color_q;
      if (acc) color_d = {cur_row[0] ^ PHASE[1], cur_col[0] ^ PHASE[0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         win_q   <= '0;
         valid_q <= 1'b0;
         color_q <= 2'd0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         win_q   <= win_d;
         valid_q <= valid_d;
         color_q <= color_d;
      end
   end

   assign out_valid = valid_q;
   assign out_win   = win_q;
   assign out_color = color_q;

`ifdef BAYER_WIN_FRAME_CHECK_EN
   logic ferr_q, ferr_d;

   // A frame that ended on its last pixel leaves the counters at (0,0).
   // Anything else at in_sof means a short or long frame.
   assign ferr_d = acc & in_sof & ((row_q != '0) | (col_q != '0));

   always_ff @(posedge clk) begin
      if (rst) ferr_q <= 1'b0;
      else     ferr_q <= ferr_d;
   end

   assign out_frame_err = ferr_q;
`else
   assign out_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_bayer_window_5x5.sv
// -----------------------------------------------------------------------------
// tb_bayer_window_5x5
//
// Four copies of the window block run side by side, one for each Bayer
// pattern, and all four see the same stimulus. The monitor keeps its own
// raster counters and an image copy. For every accept it pushes the expected
// window and per-pattern colours to a queue. Those entries are popped when
// out_valid fires.
// -----------------------------------------------------------------------------
module tb_bayer_window_5x5;

   localparam int DW = 10;
   localparam int IW = 8;
   localparam int IH = 6;
   localparam int WB = 25 * DW;

   typedef logic [WB-1:0] cv_t;

   typedef struct {
      logic [WB-1:0]   win;
      logic [3:0][1:0] col;
      int              cr;
      int              cc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_sof;
   logic [DW-1:0]   in_data;
   logic            v_x   [4];
   logic [WB-1:0]   win_x [4];
   logic [1:0]      col_x [4];
   logic            fe_x  [4];

   always #5 clk = ~clk;

   for (genvar p = 0; p < 4; p++) begin : g_pat
      bayer_window_5x5 #(
         .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .BAYER_PATTERN(p)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .in_valid     (in_valid),
         .in_sof       (in_sof),
         .in_data      (in_data),
         .out_valid    (v_x[p]),
         .out_win      (win_x[p]),
         .out_color    (col_x[p]),
         .out_frame_err(fe_x[p])
      );
   end

   int   n_chk = 0;
   int   n_err = 0;
   exp_t sb_q[$];

   task automatic chk(input string tag, input cv_t obs, input cv_t exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Colour of each 2x2 tile position. Nibble order is {c11,c10,c01,c00}.
   function automatic logic [1:0] ref_color(input int p, input int r, input int c);
      logic [7:0] tile;
      int         idx;
      case (p)
         0:       tile = {2'd3, 2'd2, 2'd1, 2'd0};  // R  Gr / Gb B
         1:       tile = {2'd2, 2'd3, 2'd0, 2'd1};  // Gr R  / B  Gb
         2:       tile = {2'd1, 2'd0, 2'd3, 2'd2};  // Gb B  / R  Gr
         default: tile = {2'd0, 2'd1, 2'd2, 2'd3};  // B  Gb / Gr R
      endcase
      idx = (r % 2) * 2 + (c % 2);
      return tile[idx*2 +: 2];
   endfunction

   // ---------------------------------------------------------------- monitor
   logic [DW-1:0] img [IH][IW];
   int   mrow = 0, mcol = 0, acc_cnt = 0, win_cnt = 0;
   bit   mon_en = 0, prev_acc = 0, prev_rst = 0, exp_err = 0, first_arm = 0;
   cv_t  last_win = '0;
   logic [1:0] last_color = 2'd0;

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("valid_wo_acc", cv_t'(v_x[0] & ~prev_acc), '0);
         chk("frame_err", cv_t'(fe_x[0]), cv_t'(exp_err));
         if (prev_rst) begin
            chk("rst_valid", cv_t'(v_x[0]), '0);
            chk("rst_win", win_x[0], '0);
            chk("rst_color", cv_t'(col_x[0]), '0);
         end else if (!prev_acc) begin
            chk("hold_win", win_x[0], last_win);
            chk("hold_color", cv_t'(col_x[0]), cv_t'(last_color));
         end
         if (v_x[0]) begin
            win_cnt++;
            if (sb_q.size() == 0) begin
               chk("sb_underflow", cv_t'(v_x[0]), '0);
            end else begin
               e = sb_q.pop_front();
               chk("win", win_x[0], e.win);
               for (int p = 0; p < 4; p++) begin
                  chk($sformatf("win_p%0d", p), win_x[p], e.win);
                  chk($sformatf("color_p%0d", p), cv_t'(col_x[p]), cv_t'(e.col[p]));
               end
               // BGGR: odd row, even column is green on a red row.
               if (e.cr == 3 && e.cc == 2)
                  chk("bggr_r3c2", cv_t'(col_x[3]), cv_t'(2'd1));
               if (first_arm) begin
                  first_arm = 0;
                  chk("first_lat", cv_t'(acc_cnt), cv_t'(37));
                  chk("first_d11", cv_t'(win_x[0][0*DW +: DW]),  cv_t'(10'h00));
                  chk("first_d33", cv_t'(win_x[0][12*DW +: DW]), cv_t'(10'h22));
                  chk("first_d55", cv_t'(win_x[0][24*DW +: DW]), cv_t'(10'h44));
                  chk("first_d15", cv_t'(win_x[0][4*DW +: DW]),  cv_t'(10'h04));
                  chk("first_d51", cv_t'(win_x[0][20*DW +: DW]), cv_t'(10'h40));
                  chk("first_color", cv_t'(col_x[0]), cv_t'(2'd0));
               end
            end
         end
      end
      last_win   = win_x[0];
      last_color = col_x[0];

      // Model the inputs that the next rising edge will sample.
      exp_err = 0;
      if (rst) begin
         mon_en    = 1;
         prev_rst  = 1;
         prev_acc  = 0;
         mrow      = 0;
         mcol      = 0;
         acc_cnt   = 0;
         first_arm = 1;
      end else begin
         prev_rst = 0;
         prev_acc = in_valid;
         if (in_valid) begin
            if (in_sof) begin
`ifdef BAYER_WIN_FRAME_CHECK_EN
               exp_err = (mrow != 0 || mcol != 0);
`endif
               mrow      = 0;
               mcol      = 0;
               acc_cnt   = 0;
               first_arm = 1;
            end
            acc_cnt++;
            img[mrow][mcol] = in_data;
            if (mrow >= 4 && mcol >= 4) begin
               for (int r = 0; r < 5; r++)
                  for (int c = 0; c < 5; c++)
                     e.win[(r*5+c)*DW +: DW] = img[mrow-4+r][mcol-4+c];
               e.cr = mrow - 2;
               e.cc = mcol - 2;
               for (int p = 0; p < 4; p++) e.col[p] = ref_color(p, e.cr, e.cc);
               sb_q.push_back(e);
            end
            if (mcol == IW - 1) begin
               mcol = 0;
               mrow = (mrow == IH - 1) ? 0 : mrow + 1;
            end else begin
               mcol++;
            end
         end
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pixel value is row*16+col of the stream's own raster position.
   // Gap cycles may carry a stray in_sof, which must be ignored.
   task automatic send_pixels(input bit sof, input bit gaps, input int n);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_sof   = 1'($urandom_range(0, 1));
               in_data  = DW'($urandom);
               @(posedge clk);
               #1;
            end
         end
         in_valid = 1'b1;
         in_sof   = (sof && i == 0);
         in_data  = DW'(((i / IW) % IH) * 16 + (i % IW));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic end_test(input string tag, input int exp_wins);
      idle(4);
      chk({tag, "_wins"}, cv_t'(win_cnt), cv_t'(exp_wins));
      chk({tag, "_sb_left"}, cv_t'(sb_q.size()), '0);
      win_cnt = 0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // basic frame
      send_pixels(1, 0, IW * IH);
      end_test("basic", 8);

      // gapped frame
      send_pixels(1, 1, IW * IH);
      end_test("gapped", 8);

      // resync: in_sof arrives at pixel (3,5)
      send_pixels(1, 0, 3 * IW + 5);
      send_pixels(1, 0, IW * IH);
      end_test("resync", 8);

      // reset mid-frame at row 3, then a stream without in_sof
      send_pixels(1, 0, 3 * IW + 3);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      send_pixels(0, 0, IW * IH);
      end_test("midrst", 8);

      // two back-to-back frames, in_sof only on the first
      send_pixels(1, 0, 2 * IW * IH);
      end_test("wrap", 16);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
